ram_dual_port_param: RTL
========================

// Module: ram_dual_port_param
//
// PURPOSE
// Parametrised simple dual-port synchronous RAM with one write port and one read port.
// Generalises the 64x8 RAM: the width, depth and read-during-write mode are configurable.
// Adds a hardware clear sequencer, a read handshake (re_in/rvalid_out) and an optional output register.
// Used as a generic buffer/scratchpad under FIFOs, line buffers and lookup tables.
//
// PARAMETERS
// DATA_W    8    data word width in bits
// ADDR_W    6    address width in bits
// DEPTH     64   number of words; must be <= 2**ADDR_W
// RDW_MODE  0    same-address read during write: 0 = old data, 1 = new (written) data
// INIT_VAL  0    DATA_W-bit value written to every location by the clear sequencer
//
// PORTS
// clk            in   1       single clock; all logic is on the rising edge
// rst_n          in   1       synchronous reset, active low
// we_in          in   1       write enable
// write_addr     in   ADDR_W  write address
// data_in        in   DATA_W  write data
// re_in          in   1       read enable
// read_addr      in   ADDR_W  read address
// data_out       out  DATA_W  read data
// rvalid_out     out  1       high for one cycle when data_out holds the result of a read
// init_busy_out  out  1       high while the clear sequencer runs; ports are ignored
//
// BEHAVIOUR
// - Reset (rst_n=0 at a clk edge):
//   - state<=CLEAR, clr_cnt<=0
//   - data_out<=0, rvalid_out<=0, init_busy_out<=1
//   - The array is not reset directly.
// - FSM CLEAR:
//   - Each cycle, ram[clr_cnt]<=INIT_VAL and clr_cnt++.
//   - When clr_cnt==DEPTH-1 is written, go to READY and set init_busy_out<=0 on that edge.
//   - CLEAR takes exactly DEPTH cycles after rst_n rises.
// - While in CLEAR:
//   - we_in and re_in are ignored; no write is performed.
//   - rvalid_out stays 0 and data_out holds its value.
// - Reset asserted mid-CLEAR or mid-READY: the sequencer restarts from clr_cnt=0. Array contents are then overwritten.
// - READY write: if we_in=1 and write_addr<DEPTH, then ram[write_addr]<=data_in. If write_addr>=DEPTH, the write is dropped.
// - READY read, base latency 1:
//   - With re_in=1 at edge N, data_out is updated at edge N and rvalid_out=1 for the following cycle.
//   - If read_addr>=DEPTH, data_out<=0 and rvalid_out is still 1.
// - No read (re_in=0): data_out holds its last value and rvalid_out<=0.
// - Same-address read and write in the same cycle:
//   - RDW_MODE=0: data_out gets the pre-write contents.
//   - RDW_MODE=1: data_out gets data_in (write-first bypass).
//   - Different addresses: the read is unaffected.
// - Back-to-back reads are accepted every cycle; there is no stall or backpressure.
//
// CONFIGURATION
// - RAM_OUT_REG_EN defined:
//   - Adds an output pipeline register; read latency becomes 2.
//   - rvalid_out is delayed with the data.
//   - The register resets to 0 and clears its valid bit during CLEAR.
// - RAM_OUT_REG_EN undefined: read latency is 1, as described above.
//
// TESTING
// 1. Release rst_n, DEPTH=64 -> init_busy_out=1 for 64 cycles then 0; reading addr 0,37,63 returns INIT_VAL.
// 2. Write 8'hA5 to addr 5, then re_in at addr 5 next cycle -> data_out=8'hA5, rvalid_out=1 one cycle later (two cycles later with RAM_OUT_REG_EN).
// 3. addr 9 holds 8'h11; write 8'h22 to addr 9 and read addr 9 in the same cycle -> 8'h11 (RDW_MODE=0), 8'h22 (RDW_MODE=1).
// 4. Pulse rst_n low at clear cycle 20 -> init_busy_out stays 1 for a full 64 more cycles; earlier writes are lost.
// 5. DEPTH=48, ADDR_W=6: write addr 50, read addr 50 -> data_out=0, rvalid_out=1; ram[50-48] is unchanged.
// 6. re_in asserted continuously over addrs 0..7 after writes of 0..7 -> data_out 0..7 on consecutive cycles, rvalid_out held high.

Source files
------------

// File: rtl/ram_dual_port_param.sv
// Simple dual-port synchronous RAM with a clear sequencer, a read handshake and a configurable read-during-write mode.
// Define RAM_OUT_REG_EN to add an output pipeline register (read latency 2 instead of 1).
module ram_dual_port_param #(
   parameter int                DATA_W   = 8,
   parameter int                ADDR_W   = 6,
   parameter int                DEPTH    = 64,
   parameter int                RDW_MODE = 0,
   parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we_in,
   input  logic [ADDR_W-1:0] write_addr,
   input  logic [DATA_W-1:0] data_in,
   input  logic              re_in,
   input  logic [ADDR_W-1:0] read_addr,
   output logic [DATA_W-1:0] data_out,
   output logic              rvalid_out,
   output logic              init_busy_out
);

   typedef enum logic {CLEAR, READY} state_e;

   localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST_C  = ADDR_W'(DEPTH-1);

   logic [DATA_W-1:0] mem_q [DEPTH];

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
   logic              busy_q, busy_d;
   logic [DATA_W-1:0] rd_data_q, rd_data_d;
   logic              rd_vld_q, rd_vld_d;

   logic              mem_we;
   logic [ADDR_W-1:0] mem_waddr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] rd_word;
   logic              wr_ok, rd_ok;

   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      busy_d    = busy_q;
      rd_data_d = rd_data_q;
      rd_vld_d  = 1'b0;
      mem_we    = 1'b0;
      mem_waddr = write_addr;
      mem_wdata = data_in;
      wr_ok     = {1'b0, write_addr} < DEPTH_C;
      rd_ok     = {1'b0, read_addr} < DEPTH_C;
      rd_word   = '0;
      // Bypass only applies when the write actually lands in the array.
      if (rd_ok) begin
         if (RDW_MODE != 0 && we_in && wr_ok && write_addr == read_addr)
            rd_word = data_in;
         else
            rd_word = mem_q[read_addr];
      end
      case (state_q)
         CLEAR: begin
            mem_we    = 1'b1;
            mem_waddr = clr_cnt_q;
            mem_wdata = INIT_VAL;
            clr_cnt_d = clr_cnt_q + 1'b1;
            if (clr_cnt_q == LAST_C) begin
               state_d = READY;
               busy_d  = 1'b0;
            end
         end
         READY: begin
            mem_we = we_in && wr_ok;
            if (re_in) begin
               rd_data_d = rd_word;
               rd_vld_d  = 1'b1;
            end
         end
         default: state_d = CLEAR;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= CLEAR;
         clr_cnt_q <= '0;
         busy_q    <= 1'b1;
         rd_data_q <= '0;
         rd_vld_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         clr_cnt_q <= clr_cnt_d;
         busy_q    <= busy_d;
         rd_data_q <= rd_data_d;
         rd_vld_q  <= rd_vld_d;
      end
   end

   // The array itself has no reset; the clear sequencer initialises it.
   always_ff @(posedge clk) begin
      if (rst_n && mem_we) mem_q[mem_waddr] <= mem_wdata;
   end

`ifdef RAM_OUT_REG_EN
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic              out_vld_q, out_vld_d;

   always_comb begin
      out_data_d = out_data_q;
      out_vld_d  = 1'b0;
      if (state_q == READY && rd_vld_q) begin
         out_data_d = rd_data_q;
         out_vld_d  = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_data_q <= '0;
         out_vld_q  <= 1'b0;
      end else begin
         out_data_q <= out_data_d;
         out_vld_q  <= out_vld_d;
      end
   end

   assign data_out   = out_data_q;
   assign rvalid_out = out_vld_q;
`else
   assign data_out   = rd_data_q;
   assign rvalid_out = rd_vld_q;
`endif

   assign init_busy_out = busy_q;

endmodule
